rnn_mem_responder: RTL

Memory/stream responder on the far end of the RNN engine's memory port and input-stream handshake. Holds the weight, bias, step-count and input-vector stores and answers engine reads with one-cycle latency. Forwards engine hidden-state writes (msel 101) to an output stream. Presents `ready` once loaded and reports completion when `busy` falls. It replaces the behavioural testbench memories so that the engine and its memories can be synthesised together.

---
 rtl/rnn_mem_pkg.sv | 37 +++
 rtl/rnn_sp_ram.sv | 26 ++
 rtl/rnn_mem_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rnn_mem_pkg.sv
// Shared definitions for the RNN memory/stream responder.
//   - Engine store-select encodings (msel) and matching preload selects (ld_sel)
//   - Store depths and their address widths
//   - Memory data width (Q4.16 signed) and step-count width
//   - Responder state enum
package rnn_mem_pkg;

   localparam int MEM_DW = 20;
   localparam int CNT_W  = 11;

   localparam int WIH_DEPTH = 2048;
   localparam int WHH_DEPTH = 4096;
   localparam int B_DEPTH   = 64;
   localparam int WIH_AW    = $clog2(WIH_DEPTH);
   localparam int WHH_AW    = $clog2(WHH_DEPTH);
   localparam int B_AW      = $clog2(B_DEPTH);

   localparam logic [2:0] MSEL_WIH  = 3'b000;
   localparam logic [2:0] MSEL_BIH  = 3'b001;
   localparam logic [2:0] MSEL_WHH  = 3'b010;
   localparam logic [2:0] MSEL_BHH  = 3'b011;
   localparam logic [2:0] MSEL_CNT  = 3'b100;
   localparam logic [2:0] MSEL_HOUT = 3'b101;
   localparam logic [2:0] LSEL_X    = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // msel 110/111 address nothing the engine may touch.
   function automatic logic is_illegal_msel(input logic [2:0] sel);
      return sel[2] & sel[1];
   endfunction

endpackage

// File: rtl/rnn_sp_ram.sv
// Simple 1R1W RAM with registered read, no reset on contents or output.
//   clk          clock
//   we/waddr/wdata  write port
//   re/raddr     read port; rdata updates only on an edge with re=1, else holds
module rnn_sp_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 20,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/rnn_mem_responder.sv
// Far-end responder for the RNN engine memory port and input-stream handshake.
// Holds W_ih, b_ih, W_hh, b_hh, step count and input vectors; answers engine
// reads with one-cycle latency, forwards hidden-state writes (msel 101) to an
// output stream, presents ready once loaded and pulses done when busy falls.
//   clk, reset                 clock, synchronous active-high reset
//   ld_en/ld_sel/ld_addr/ld_data  preload port (IDLE only)
//   ld_done                    preload complete, arms ready
//   busy                       engine busy
//   mce/msel/maddr/mdata_w     engine memory port
//   i_en                       engine input-vector request
//   ready                      to engine, high in ARMED
//   mdata_r                    read data
//   idata                      current input vector
//   out_valid/out_t/out_h/out_data  forwarded hidden-state write
//   done                       one-cycle completion pulse
//   err                        sticky illegal-access flag
module rnn_mem_responder
   import rnn_mem_pkg::*;
#(
   parameter int X_DEPTH = 64,
   parameter int DW      = MEM_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_en,
   input  logic [2:0]    ld_sel,
   input  logic [11:0]   ld_addr,
   input  logic [31:0]   ld_data,
   input  logic          ld_done,
   input  logic          busy,
   input  logic          mce,
   input  logic [2:0]    msel,
   input  logic [16:0]   maddr,
   input  logic [DW-1:0] mdata_w,
   input  logic          i_en,
   output logic          ready,
   output logic [DW-1:0] mdata_r,
   output logic [31:0]   idata,
   output logic          out_valid,
   output logic [10:0]   out_t,
   output logic [5:0]    out_h,
   output logic [DW-1:0] out_data,
   output logic          done,
   output logic          err
);

   localparam int X_AW = $clog2(X_DEPTH);
   localparam logic [X_AW-1:0] X_LAST = X_AW'(X_DEPTH - 1);

   state_t state, state_nx;

   logic [DW-1:0]    q_wih, q_bih, q_whh, q_bhh;
   logic [31:0]      q_x;
   logic [CNT_W-1:0] cnt;
   // rsel picks which store drives mdata_r; anything other than the four RAMs
   // selects aux, which carries the step count or the zero of an illegal access.
   logic [2:0]       rsel;
   logic [CNT_W-1:0] aux;
   logic [X_AW-1:0]  x_ptr;
   logic             x_vld;

   logic ld_ok, arm, x_rd;

   // Loads are only accepted in IDLE; reads go to the read ports in any state.
   assign ld_ok = ld_en && (state == ST_IDLE);
   assign arm   = (state == ST_IDLE) && ld_done;
   assign x_rd  = i_en && ((state == ST_ARMED) || (state == ST_RUN));

   rnn_sp_ram #(.DEPTH(WIH_DEPTH), .WIDTH(DW)) u_wih (
      .clk   (clk),
      .we    (ld_ok && (ld_sel == MSEL_WIH)),
      .waddr (ld_addr[WIH_AW-1:0]),
      .wdata (ld_data[DW-1:0]),
      .re    (mce && (msel == MSEL_WIH)),
      .raddr (maddr[WIH_AW-1:0]),
      .rdata (q_wih)
   );

   rnn_sp_ram #(.DEPTH(B_DEPTH), .WIDTH(DW)) u_bih (
      .clk   (clk),
      .we    (ld_ok && (ld_sel == MSEL_BIH)),
      .waddr (ld_addr[B_AW-1:0]),
      .wdata (ld_data[DW-1:0]),
      .re    (mce && (msel == MSEL_BIH)),
      .raddr (maddr[B_AW-1:0]),
      .rdata (q_bih)
   );

   rnn_sp_ram #(.DEPTH(WHH_DEPTH), .WIDTH(DW)) u_whh (
      .clk   (clk),
      .we    (ld_ok && (ld_sel == MSEL_WHH)),
      .waddr (ld_addr[WHH_AW-1:0]),
      .wdata (ld_data[DW-1:0]),
      .re    (mce && (msel == MSEL_WHH)),
      .raddr (maddr[WHH_AW-1:0]),
      .rdata (q_whh)
   );

   rnn_sp_ram #(.DEPTH(B_DEPTH), .WIDTH(DW)) u_bhh (
      .clk   (clk),
      .we    (ld_ok && (ld_sel == MSEL_BHH)),
      .waddr (ld_addr[B_AW-1:0]),
      .wdata (ld_data[DW-1:0]),
      .re    (mce && (msel == MSEL_BHH)),
      .raddr (maddr[B_AW-1:0]),
      .rdata (q_bhh)
   );

   rnn_sp_ram #(.DEPTH(X_DEPTH), .WIDTH(32)) u_xmem (
      .clk   (clk),
      .we    (ld_ok && (ld_sel == LSEL_X)),
      .waddr (ld_addr[X_AW-1:0]),
      .wdata (ld_data),
      .re    (x_rd),
      .raddr (x_ptr),
      .rdata (q_x)
   );

   // Step count is a store: no reset.
   always_ff @(posedge clk) begin
      if (ld_ok && (ld_sel == MSEL_CNT)) cnt <= ld_data[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (ld_done) state_nx = ST_ARMED;
         ST_ARMED: if (busy)    state_nx = ST_RUN;
         ST_RUN:   if (!busy)   state_nx = ST_IDLE;
         default:               state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      ready = (state == ST_ARMED);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsel      <= MSEL_CNT;
         aux       <= '0;
         out_valid <= 1'b0;
         out_t     <= '0;
         out_h     <= '0;
         out_data  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         x_ptr     <= '0;
         x_vld     <= 1'b0;
      end else begin
         done      <= (state == ST_RUN) && !busy;
         out_valid <= mce && (msel == MSEL_HOUT);
         if (mce) begin
            if (msel == MSEL_HOUT) begin
               out_t    <= maddr[16:6];
               out_h    <= maddr[5:0];
               out_data <= mdata_w;
            end else if (is_illegal_msel(msel)) begin
               rsel <= MSEL_CNT;
               aux  <= '0;
               err  <= 1'b1;
            end else begin
               rsel <= msel;
               if (msel == MSEL_CNT) aux <= cnt;
            end
         end
         if (arm)
            x_ptr <= '0;
         else if (x_rd)
            x_ptr <= (x_ptr == X_LAST) ? '0 : x_ptr + 1'b1;
         if (x_rd) x_vld <= 1'b1;
      end
   end

   always_comb begin
      case (rsel)
         MSEL_WIH: mdata_r = q_wih;
         MSEL_BIH: mdata_r = q_bih;
         MSEL_WHH: mdata_r = q_whh;
         MSEL_BHH: mdata_r = q_bhh;
         default:  mdata_r = {{(DW-CNT_W){1'b0}}, aux};
      endcase
   end

   // The xmem output register is not reset, so idata reads zero until the
   // first honoured request after reset.
   assign idata = x_vld ? q_x : '0;

endmodule
